// File: rtl/register_file_v2.sv
// Parametrised multi-read, single-write register file with a reset-time clear sweep,
// optional write-to-read bypass and an optional hardwired-zero entry 0.
module register_file_v2 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  output logic                     wr_dropped,
  input  logic                     wr_ena,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  // When DEPTH fills the address space every address is valid and no compare is needed.
  localparam bit                FULL_RANGE = (DEPTH == (32'd1 << ADDR_W));
  localparam logic [ADDR_W-1:0] LAST       = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_en_c;
  logic              wr_in_range_c;
  logic              wr_commit_c;

  logic [WIDTH-1:0]  mem [DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Next state: sweep one entry per edge, leave CLEAR on the last entry
  always_comb begin
    state_next = state;
    clr_en_c   = 1'b0;
    case (state)
      CLEAR: begin
        clr_en_c = 1'b1;
        if (clr_ptr == LAST) state_next = READY;
      end
      default: state_next = READY;
    endcase
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst)           clr_ptr <= '0;
    else if (clr_en_c) clr_ptr <= clr_ptr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                  wr_dropped <= 1'b0;
    else if (busy && wr_ena)  wr_dropped <= 1'b1;
  end

  if (FULL_RANGE) begin : g_wr_full
    assign wr_in_range_c = 1'b1;
  end else begin : g_wr_part
    assign wr_in_range_c = (wr_addr <= LAST);
  end

  // A write only lands outside reset, in READY, in range and not on a hardwired zero entry
  assign wr_commit_c = !rst && (state == READY) && wr_ena && wr_in_range_c &&
                       !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (!rst && clr_en_c) mem[clr_ptr] <= '0;
    else if (wr_commit_c) mem[wr_addr] <= wr_data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              ok;
    logic [WIDTH-1:0]  word;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    if (FULL_RANGE) begin : g_full
      assign ok = 1'b1;
    end else begin : g_part
      assign ok = (addr <= LAST);
    end

    // Priority: busy, out of range, zero entry, bypass, stored value
    always_comb begin
      word = '0;
      if (!busy && ok && !((ZERO_REG != 0) && (addr == '0))) begin
        if ((BYPASS != 0) && wr_commit_c && (wr_addr == addr)) word = wr_data;
        else                                                   word = mem[addr];
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = word;
  end

endmodule

// File: tb/tb_register_file_v2.sv
// Directed bench for register_file_v2: two 32x32 instances (bypass on/off) sharing
// stimulus, plus an 8-bit, 12-entry, three-read-port instance.
module tb_register_file_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic        busy_a, drop_a, busy_b, drop_b;
  logic [63:0] rd_data_a, rd_data_b;

  logic        rst_c;
  logic        wr_ena_c;
  logic [3:0]  wr_addr_c;
  logic [7:0]  wr_data_c;
  logic [11:0] rd_addr_c;
  logic        busy_c, drop_c;
  logic [23:0] rd_data_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  register_file_v2 #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .busy(busy_a), .wr_dropped(drop_a), .wr_ena(wr_ena),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a));

  register_file_v2 #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .busy(busy_b), .wr_dropped(drop_b), .wr_ena(wr_ena),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b));

  register_file_v2 #(.WIDTH(8), .DEPTH(12), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst_c), .busy(busy_c), .wr_dropped(drop_c), .wr_ena(wr_ena_c),
    .wr_addr(wr_addr_c), .wr_data(wr_data_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_ena = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_ena = 1'b0;
  endtask

  task automatic sweep_len_ab(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin tick(); n++; end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = {5'd9, 5'd3};
    repeat (3) tick();
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
    n_cmp++; if (drop_a !== 1'b0) begin n_bad++; $display("FAIL reset_dropped: got %b expected 0", drop_a); end
    n_cmp++; if (rd_data_a !== 64'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h expected 0", rd_data_a); end
    rst = 1'b0;
    sweep_len_ab(n);
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL reset_sweep_len: got %0d expected 32", n); end
    n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd31, 32'h12345678);
    rd_addr = {5'd31, 5'd5}; #1;
    n_cmp++; if (rd_data_a !== {32'h12345678, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wr_rd_a: got %h expected 12345678deadbeef", rd_data_a); end
    n_cmp++; if (rd_data_b !== {32'h12345678, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wr_rd_b: got %h expected 12345678deadbeef", rd_data_b); end
    do_write(5'd0, 32'hFFFFFFFF);
    rd_addr = {5'd0, 5'd0}; #1;
    n_cmp++; if (rd_data_a !== 64'h0) begin n_bad++; $display("FAIL zero_reg_rd: got %h expected 0", rd_data_a); end
    n_cmp++; if (drop_a !== 1'b0) begin n_bad++; $display("FAIL zero_reg_dropped: got %b expected 0", drop_a); end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 32'h1);
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd7}; #1;
    n_cmp++; if (rd_data_a !== {2{32'hA5A5A5A5}}) begin n_bad++; $display("FAIL bypass_on: got %h expected a5a5a5a5a5a5a5a5", rd_data_a); end
    n_cmp++; if (rd_data_b !== {2{32'h1}}) begin n_bad++; $display("FAIL bypass_off_same: got %h expected 0000000100000001", rd_data_b); end
    tick();
    wr_ena = 1'b0; #1;
    n_cmp++; if (rd_data_b !== {2{32'hA5A5A5A5}}) begin n_bad++; $display("FAIL bypass_off_next: got %h expected a5a5a5a5a5a5a5a5", rd_data_b); end
  endtask

  task automatic test_clear_sweep();
    int n;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    sweep_len_ab(n);
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL clear_sweep_len: got %0d expected 32", n); end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)}; #1;
      n_cmp++; if (rd_data_a !== 64'h0) begin n_bad++; $display("FAIL clear_entry_%0d: got %h expected 0", a, rd_data_a); end
    end
  endtask

  task automatic test_write_busy();
    int n;
    do_write(5'd3, 32'h99);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; rd_addr = {5'd3, 5'd3}; #1;
    n_cmp++; if (rd_data_a !== 64'h0) begin n_bad++; $display("FAIL busy_rd_zero: got %h expected 0", rd_data_a); end
    tick();
    wr_ena = 1'b0;
    n_cmp++; if (drop_a !== 1'b1) begin n_bad++; $display("FAIL busy_dropped_set: got %b expected 1", drop_a); end
    sweep_len_ab(n);
    n_cmp++; if (n !== 21) begin n_bad++; $display("FAIL busy_remaining_sweep: got %0d expected 21", n); end
    n_cmp++; if (drop_a !== 1'b1) begin n_bad++; $display("FAIL busy_dropped_hold: got %b expected 1", drop_a); end
    #1;
    n_cmp++; if (rd_data_a !== 64'h0) begin n_bad++; $display("FAIL busy_entry3: got %h expected 0", rd_data_a); end
    rst = 1'b1; tick();
    n_cmp++; if (drop_a !== 1'b0) begin n_bad++; $display("FAIL busy_dropped_clr: got %b expected 0", drop_a); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rst = 1'b0;
    repeat (20) tick();
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b expected 1", busy_a); end
    rst = 1'b1; tick();
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL mid_busy_rst: got %b expected 1", busy_a); end
    rst = 1'b0;
    sweep_len_ab(n);
    n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL mid_sweep_len: got %0d expected 32", n); end
  endtask

  task automatic test_generics();
    int n;
    wr_ena_c = 1'b0; wr_addr_c = '0; wr_data_c = '0; rd_addr_c = '0;
    repeat (2) tick();
    rst_c = 1'b0;
    n = 0;
    while (busy_c === 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL gen_sweep_len: got %0d expected 12", n); end
    wr_ena_c = 1'b1; wr_addr_c = 4'd11; wr_data_c = 8'd13;
    tick();
    wr_addr_c = 4'd14; wr_data_c = 8'hEE;
    tick();
    wr_ena_c = 1'b0;
    rd_addr_c = {4'd11, 4'd11, 4'd11}; #1;
    n_cmp++; if (rd_data_c !== {3{8'd13}}) begin n_bad++; $display("FAIL gen_three_ports: got %h expected 0d0d0d", rd_data_c); end
    rd_addr_c = {4'd11, 4'd11, 4'd14}; #1;
    n_cmp++; if (rd_data_c !== {8'd13, 8'd13, 8'd0}) begin n_bad++; $display("FAIL gen_out_of_range: got %h expected 0d0d00", rd_data_c); end
    n_cmp++; if (drop_c !== 1'b0) begin n_bad++; $display("FAIL gen_dropped: got %b expected 0", drop_c); end
  endtask

  initial begin
    rst_c = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_sweep();
    test_write_busy();
    test_reset_mid_sweep();
    test_generics();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
